seg7_scan_mux4: RTL and testbench

- Time-multiplexed driver for a 4-digit common-anode seven-segment display.
- Takes four pre-decoded 7-bit segment patterns: digits 0..3, segments A..G.
- Cycles through the digits at a prescaled refresh rate, driving one shared segment bus and four active-low anode enables.
- Sits between the segment-pattern logic and the board display pins.

---
 rtl/seg7_scan_mux4.sv | 99 +++++++++
 tb/tb_seg7_scan_mux4.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux4.sv
// seg7_scan_mux4: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. It scans digits 0..3 and switches each one every PRESCALE
// clocks. It drives one shared segment bus {A..G} and four active-low anodes.
// Outputs are registered, so they appear one clock after the selected digit changes.
// Optional feature: define DIGIT_BLANK_EN to turn off every anode and segment for the
// first BLANK_CYCLES clocks of each digit slot. This suppresses ghosting.
module seg7_scan_mux4 #(
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic A0, input logic B0, input logic C0, input logic D0,
    input  logic E0, input logic F0, input logic G0,
    input  logic A1, input logic B1, input logic C1, input logic D1,
    input  logic E1, input logic F1, input logic G1,
    input  logic A2, input logic B2, input logic C2, input logic D2,
    input  logic E2, input logic F2, input logic G2,
    input  logic A3, input logic B3, input logic C3, input logic D3,
    input  logic E3, input logic F3, input logic G3,
    output logic A,  output logic B,  output logic C,  output logic D,
    output logic E,  output logic F,  output logic G,
    output logic An0, output logic An1, output logic An2, output logic An3
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    // Reject parameter sets that would break the slot timing
    if (PRESCALE < 2 || BLANK_CYCLES >= PRESCALE) begin : g_bad_param
        $error("seg7_scan_mux4: need PRESCALE >= 2 and BLANK_CYCLES < PRESCALE");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q,  an_d;
    logic [6:0]       seg_q, seg_d;
    logic [6:0]       dig_c [4];
    logic             blank_c;

    // Pack the per-digit segment inputs in {A..G} order
    always_comb begin
        dig_c[0] = {A0, B0, C0, D0, E0, F0, G0};
        dig_c[1] = {A1, B1, C1, D1, E1, F1, G1};
        dig_c[2] = {A2, B2, C2, D2, E2, F2, G2};
        dig_c[3] = {A3, B3, C3, D3, E3, F3, G3};
    end

    // Prescaler wraps at PRESCALE-1; the digit index advances on the same edge
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Anti-ghosting blank window at the start of each slot
    always_comb begin
`ifdef DIGIT_BLANK_EN
        blank_c = (cnt_q < CNT_W'(BLANK_CYCLES));
`else
        blank_c = 1'b0;
`endif
    end

    // Next output drive: one anode low for the current index, segments passed through
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        if (!blank_c) begin
            an_d[idx_q] = 1'b0;
            seg_d       = dig_c[idx_q];
        end
    end

    // State and output registers; reset blanks the display immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign {A, B, C, D, E, F, G} = seg_q;
    assign An0 = an_q[0];
    assign An1 = an_q[1];
    assign An2 = an_q[2];
    assign An3 = an_q[3];

endmodule

// File: tb/tb_seg7_scan_mux4.sv
// Directed bench for seg7_scan_mux4 with PRESCALE=8 and BLANK_CYCLES=4.
// Anodes are compared as {An0,An1,An2,An3} and segments as {A..G}.
// When the bench is built with DIGIT_BLANK_EN, expected values account for
// the blank window at the start of each slot.
module tb_seg7_scan_mux4;

    localparam int P  = 8;
    localparam int BL = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [6:0] d0, d1, d2, d3;
    logic A, B, C, D, E, F, G, An0, An1, An2, An3;

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;

    seg7_scan_mux4 #(.PRESCALE(P), .BLANK_CYCLES(BL)) dut (
        .clock(clock), .reset(reset),
        .A0(d0[6]), .B0(d0[5]), .C0(d0[4]), .D0(d0[3]), .E0(d0[2]), .F0(d0[1]), .G0(d0[0]),
        .A1(d1[6]), .B1(d1[5]), .C1(d1[4]), .D1(d1[3]), .E1(d1[2]), .F1(d1[1]), .G1(d1[0]),
        .A2(d2[6]), .B2(d2[5]), .C2(d2[4]), .D2(d2[3]), .E2(d2[2]), .F2(d2[1]), .G2(d2[0]),
        .A3(d3[6]), .B3(d3[5]), .C3(d3[4]), .D3(d3[3]), .E3(d3[2]), .F3(d3[1]), .G3(d3[0]),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
        .An0(An0), .An1(An1), .An2(An2), .An3(An3)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         n;
        logic [3:0] an;
        logic [6:0] seg;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [3:0] an_now();
        return {An0, An1, An2, An3};
    endfunction

    function automatic logic [6:0] seg_now();
        return {A, B, C, D, E, F, G};
    endfunction

    // Expected output after applying the optional blank window for cycle n after release
    function automatic logic [10:0] gate(input int cyc, input logic [3:0] an, input logic [6:0] seg);
`ifdef DIGIT_BLANK_EN
        if (((cyc - 1) % P) < BL) return {4'b1111, 7'b1111111};
`endif
        return {an, seg};
    endfunction

    function automatic bit in_blank(input int cyc);
`ifdef DIGIT_BLANK_EN
        return ((cyc - 1) % P) < BL;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        tick();
        n++;
    endtask

    task automatic check(input string name, input logic [10:0] exp_v);
        logic [10:0] got;
        got = {an_now(), seg_now()};
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s n=%0d: an=%b seg=%b, required an=%b seg=%b",
                     name, n, got[10:7], got[6:0], exp_v[10:7], exp_v[6:0]);
        end
    endtask

    task automatic check_onehot();
        logic [3:0] an;
        bit ok;
        an = an_now();
        n_checks++;
        ok = in_blank(n) ? (an == 4'b1111) : $onehot(~an);
        if (!ok) begin
            n_fail++;
            $display("FAIL onehot n=%0d: an=%b, required exactly one low%s",
                     n, an, in_blank(n) ? " (blank: 1111)" : "");
        end
    endtask

    initial begin
        tbl[0] = '{1,  4'b0111, 7'b1111111};
        tbl[1] = '{8,  4'b0111, 7'b1111111};
        tbl[2] = '{9,  4'b1011, 7'b0000000};
        tbl[3] = '{16, 4'b1011, 7'b0000000};
        tbl[4] = '{17, 4'b1101, 7'b1010101};
        tbl[5] = '{24, 4'b1101, 7'b1010101};
        tbl[6] = '{25, 4'b1110, 7'b0101010};
        tbl[7] = '{32, 4'b1110, 7'b0101010};
        tbl[8] = '{33, 4'b0111, 7'b1111111};
        tbl[9] = '{13, 4'b1011, 7'b0000000};

        // Reset held while inputs toggle: display stays blank
        for (int i = 0; i < 3; i++) begin
            d0 = 7'($urandom); d1 = 7'($urandom); d2 = 7'($urandom); d3 = 7'($urandom);
            tick();
            check("reset_hold", {4'b1111, 7'b1111111});
        end

        d0 = 7'b1111111; d1 = 7'b0000000; d2 = 7'b1010101; d3 = 7'b0101010;
        reset = 1'b0;
        n = 0;

        // One full scan plus the wrap back to digit 0
        for (int c = 1; c <= 4 * P + 1; c++) begin
            step();
            check_onehot();
            for (int k = 0; k < 10; k++)
                if (tbl[k].n == n) check("scan_vec", gate(n, tbl[k].an, tbl[k].seg));
        end

        // Mid-slot input change on digit 2 appears one clock later
        while (n < 52) step();
        check("d2_before", gate(n, 4'b1101, 7'b1010101));
        d2 = 7'b0000001;
        step();
        check("d2_after", gate(n, 4'b1101, 7'b0000001));
        while (n < 56) step();
        check("d2_slot_end", gate(n, 4'b1101, 7'b0000001));
        step();
        check("d3_after_change", gate(n, 4'b1110, 7'b0101010));

        // Asynchronous reset during the digit-3 slot
        while (n < 61) step();
        check("d3_pre_reset", gate(n, 4'b1110, 7'b0101010));
        #2 reset = 1'b1;
        #1 check("async_reset", {4'b1111, 7'b1111111});
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_held", {4'b1111, 7'b1111111});
        end
        reset = 1'b0;
        n = 0;
        step();
        check("restart_first", gate(n, 4'b0111, 7'b1111111));
        while (n < P) step();
        check("restart_slot_end", gate(n, 4'b0111, 7'b1111111));
        step();
        check("restart_next", gate(n, 4'b1011, 7'b0000000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
